// File: rtl/bus_initiator.sv
// Core-side initiator: turns one load/store request into 1..8 little-endian
// byte transactions on the 8-bit system bus and returns the assembled result.
module bus_initiator #(
   parameter int ADDR_WIDTH   = 64,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic [63:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [63:0]           rsp_rdata,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [7:0]            bus_data_in,
   input  logic [7:0]            bus_data_out
);

   typedef enum logic [1:0] {IDLE, XFER, WAIT, RESP} state_t;

   localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY);

   state_t                state, state_nxt;
   logic                  we_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [63:0]           wdata_r;
   logic [63:0]           rdata_r;
   logic [2:0]            cnt;
   logic [2:0]            last;
   logic [3:0]            lat;
   logic                  last_byte;
   logic                  lat_done;

   assign last_byte = (cnt == last);
   assign lat_done  = (lat == 4'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_valid) state_nxt = XFER;
         XFER: begin
            if (!we_r)          state_nxt = WAIT;
            else if (last_byte) state_nxt = RESP;
         end
         WAIT: if (lat_done) state_nxt = last_byte ? RESP : XFER;
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request fields are captured only at acceptance; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         addr_r  <= req_addr;
         wdata_r <= req_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_r    <= 1'b0;
         last    <= 3'd0;
         cnt     <= 3'd0;
         lat     <= 4'd0;
         rdata_r <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_r    <= req_we;
                  cnt     <= 3'd0;
                  rdata_r <= 64'd0;
                  case (req_size)
                     2'd0:    last <= 3'd0;
                     2'd1:    last <= 3'd1;
                     2'd2:    last <= 3'd3;
                     default: last <= 3'd7;
                  endcase
               end
            end
            XFER: begin
               if (!we_r)           lat <= LAT_INIT;
               else if (!last_byte) cnt <= cnt + 3'd1;
            end
            WAIT: begin
               lat <= lat - 4'd1;
               if (lat_done) begin
                  rdata_r[{cnt, 3'b000} +: 8] <= bus_data_out;
                  if (!last_byte) cnt <= cnt + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode registered state only; the read byte never reaches an output combinationally.
   always_comb begin
      req_ready   = (state == IDLE) && !reset;
      rsp_valid   = (state == RESP);
      rsp_rdata   = (state == RESP) ? rdata_r : 64'd0;
      bus_we      = (state == XFER) && we_r;
      bus_addr    = '0;
      bus_data_in = 8'd0;
      if (state == XFER || state == WAIT) bus_addr = addr_r + ADDR_WIDTH'(cnt);
      if (state == XFER && we_r)          bus_data_in = wdata_r[{cnt, 3'b000} +: 8];
   end

endmodule
